// File: rtl/blake2_block_sched.sv
`timescale 1ns/1ps
// BLAKE2s block sequencer: packs host bytes into little-endian message words,
// zero-fills short last blocks, launches compressions and streams out the digest.
module blake2_block_sched #(
   parameter int SLOW_DIV = 4
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic [5:0]  kk_i,
   input  logic [5:0]  nn_i,
   input  logic [63:0] ll_i,
   input  logic        data_v_i,
   input  logic [7:0]  data_i,
   input  logic [5:0]  data_idx_i,
   input  logic        block_first_i,
   input  logic        block_last_i,
   input  logic        slow_output_i,
   output logic        ready_v_o,
   output logic        m_wr_o,
   output logic [3:0]  m_idx_o,
   output logic [31:0] m_word_o,
   output logic        cmp_start_o,
   output logic        cmp_last_o,
   output logic [63:0] t_o,
   input  logic        cmp_done_i,
   output logic [4:0]  h_idx_o,
   input  logic [7:0]  h_byte_i,
   output logic        hash_v_o,
   output logic [7:0]  hash_o,
   output logic        err_o
);

   localparam int GW = $clog2(SLOW_DIV);
   localparam logic [GW-1:0] GAP_SLOW = GW'(SLOW_DIV - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FILL, S_COMP, S_OUT} state_t;

   state_t        state_q, state_d;
   logic [5:0]    b_q, b_d;
   logic [63:0]   t_q, t_d;
   logic [31:0]   word_q, word_d;
   logic          last_q, last_d;
   logic          key_blk_q, key_blk_d;
   logic [3:0]    fill_idx_q, fill_idx_d;
   logic          started_q, started_d;
   logic          err_q, err_d;
   logic          ready_q, ready_d;
   logic          m_wr_q, m_wr_d;
   logic [3:0]    m_idx_q, m_idx_d;
   logic [31:0]   m_word_q, m_word_d;
   logic          cmp_start_q, cmp_start_d;
   logic          cmp_last_q, cmp_last_d;
   logic [63:0]   t_o_q, t_o_d;
   logic [4:0]    h_idx_q, h_idx_d;
   logic [5:0]    nxt_idx_q, nxt_idx_d;
   logic          all_iss_q, all_iss_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          slow_q, slow_d;
   logic          iss_q, iss_d;
   logic          iss_last_q, iss_last_d;
   logic          pend_q, pend_d;
   logic          pend_last_q, pend_last_d;
   logic          hash_v_q, hash_v_d;
   logic [7:0]    hash_q, hash_d;

   logic          accept;
   logic [5:0]    b_cur;
   logic [63:0]   t_inc;
   logic          end_last;
   logic          key_cur;
   logic [31:0]   word_new;

   // A byte in IDLE starts a fresh message, so its position and count restart at zero.
   assign accept   = data_v_i && ((state_q == S_IDLE && block_first_i) || state_q == S_LOAD);
   assign b_cur    = (state_q == S_IDLE) ? 6'd0 : b_q;
   assign t_inc    = ((state_q == S_IDLE) ? 64'd0 : t_q) + 64'd1;
   assign end_last = block_last_i && (t_inc == ll_i);
   assign key_cur  = (state_q == S_IDLE) ? (kk_i != 6'd0) : key_blk_q;

   // Lane 0 clears the word so a partial final word carries zero upper lanes.
   always_comb begin
      word_new = word_q;
      case (b_cur[1:0])
         2'd0: word_new = {24'd0, data_i};
         2'd1: word_new[15:8]  = data_i;
         2'd2: word_new[23:16] = data_i;
         default: word_new[31:24] = data_i;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      b_d         = b_q;
      t_d         = t_q;
      word_d      = word_q;
      last_d      = last_q;
      key_blk_d   = key_blk_q;
      fill_idx_d  = fill_idx_q;
      started_d   = started_q;
      err_d       = err_q;
      m_wr_d      = 1'b0;
      m_idx_d     = m_idx_q;
      m_word_d    = m_word_q;
      cmp_start_d = 1'b0;
      cmp_last_d  = 1'b0;
      t_o_d       = t_o_q;
      h_idx_d     = h_idx_q;
      nxt_idx_d   = nxt_idx_q;
      all_iss_d   = all_iss_q;
      gap_d       = gap_q;
      slow_d      = slow_q;
      iss_d       = 1'b0;
      iss_last_d  = 1'b0;
      pend_d      = iss_q;
      pend_last_d = iss_last_q;
      hash_v_d    = pend_q;
      hash_d      = pend_q ? h_byte_i : hash_q;

      case (state_q)
         S_IDLE, S_LOAD: begin
            if (accept) begin
               state_d   = S_LOAD;
               word_d    = word_new;
               t_d       = t_inc;
               b_d       = b_cur + 6'd1;
               key_blk_d = key_cur;
               err_d     = ((state_q == S_IDLE) ? 1'b0 : err_q) | (data_idx_i != b_cur);
               if (b_cur[1:0] == 2'd3 || end_last) begin
                  m_wr_d   = 1'b1;
                  m_idx_d  = b_cur[5:2];
                  m_word_d = word_new;
               end
               if (b_cur == 6'd63) begin
                  state_d   = S_COMP;
                  last_d    = end_last;
                  b_d       = 6'd0;
                  started_d = 1'b0;
                  key_blk_d = 1'b0;
                  if (block_last_i && !end_last) err_d = 1'b1;
               end else if (end_last) begin
                  // A padded key block is always full; ending it early is a host error.
                  state_d    = (b_cur[5:2] == 4'd15) ? S_COMP : S_FILL;
                  fill_idx_d = b_cur[5:2] + 4'd1;
                  last_d     = 1'b1;
                  b_d        = 6'd0;
                  started_d  = 1'b0;
                  key_blk_d  = 1'b0;
                  if (key_cur) err_d = 1'b1;
               end
            end
         end
         S_FILL: begin
            m_wr_d     = 1'b1;
            m_idx_d    = fill_idx_q;
            m_word_d   = 32'd0;
            fill_idx_d = fill_idx_q + 4'd1;
            if (fill_idx_q == 4'd15) state_d = S_COMP;
         end
         S_COMP: begin
            if (!started_q) begin
               cmp_start_d = 1'b1;
               cmp_last_d  = last_q;
               t_o_d       = t_q;
               started_d   = 1'b1;
            end else if (cmp_done_i) begin
               if (last_q) begin
                  state_d    = S_OUT;
                  iss_d      = 1'b1;
                  iss_last_d = (nn_i == 6'd1);
                  all_iss_d  = (nn_i == 6'd1);
                  h_idx_d    = 5'd0;
                  nxt_idx_d  = 6'd1;
                  slow_d     = slow_output_i;
                  gap_d      = slow_output_i ? GAP_SLOW : '0;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_OUT: begin
            // Read pipeline: index issued, core byte one cycle later, registered out after that.
            if (!all_iss_q) begin
               if (gap_q == '0) begin
                  iss_d      = 1'b1;
                  iss_last_d = (nxt_idx_q == nn_i - 6'd1);
                  all_iss_d  = (nxt_idx_q == nn_i - 6'd1);
                  h_idx_d    = nxt_idx_q[4:0];
                  nxt_idx_d  = nxt_idx_q + 6'd1;
                  gap_d      = slow_q ? GAP_SLOW : '0;
               end else begin
                  gap_d = gap_q - GW'(1);
               end
            end
            if (pend_q && pend_last_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (data_v_i && (state_q == S_FILL || state_q == S_COMP || state_q == S_OUT)) err_d = 1'b1;
      ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q     <= S_IDLE;
         b_q         <= 6'd0;
         t_q         <= 64'd0;
         word_q      <= 32'd0;
         last_q      <= 1'b0;
         key_blk_q   <= 1'b0;
         fill_idx_q  <= 4'd0;
         started_q   <= 1'b0;
         err_q       <= 1'b0;
         ready_q     <= 1'b0;
         m_wr_q      <= 1'b0;
         m_idx_q     <= 4'd0;
         m_word_q    <= 32'd0;
         cmp_start_q <= 1'b0;
         cmp_last_q  <= 1'b0;
         t_o_q       <= 64'd0;
         h_idx_q     <= 5'd0;
         nxt_idx_q   <= 6'd0;
         all_iss_q   <= 1'b0;
         gap_q       <= '0;
         slow_q      <= 1'b0;
         iss_q       <= 1'b0;
         iss_last_q  <= 1'b0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         hash_v_q    <= 1'b0;
         hash_q      <= 8'd0;
      end else begin
         state_q     <= state_d;
         b_q         <= b_d;
         t_q         <= t_d;
         word_q      <= word_d;
         last_q      <= last_d;
         key_blk_q   <= key_blk_d;
         fill_idx_q  <= fill_idx_d;
         started_q   <= started_d;
         err_q       <= err_d;
         ready_q     <= ready_d;
         m_wr_q      <= m_wr_d;
         m_idx_q     <= m_idx_d;
         m_word_q    <= m_word_d;
         cmp_start_q <= cmp_start_d;
         cmp_last_q  <= cmp_last_d;
         t_o_q       <= t_o_d;
         h_idx_q     <= h_idx_d;
         nxt_idx_q   <= nxt_idx_d;
         all_iss_q   <= all_iss_d;
         gap_q       <= gap_d;
         slow_q      <= slow_d;
         iss_q       <= iss_d;
         iss_last_q  <= iss_last_d;
         pend_q      <= pend_d;
         pend_last_q <= pend_last_d;
         hash_v_q    <= hash_v_d;
         hash_q      <= hash_d;
      end
   end

   assign ready_v_o   = ready_q;
   assign m_wr_o      = m_wr_q;
   assign m_idx_o     = m_idx_q;
   assign m_word_o    = m_word_q;
   assign cmp_start_o = cmp_start_q;
   assign cmp_last_o  = cmp_last_q;
   assign t_o         = t_o_q;
   assign h_idx_o     = h_idx_q;
   assign hash_v_o    = hash_v_q;
   assign hash_o      = hash_q;
   assign err_o       = err_q;

endmodule

// File: doc/blake2_block_sched.md
# blake2_block_sched

Block-level sequencer between the byte-serial host front end and the BLAKE2s compression core. Packs incoming message bytes into 32-bit little-endian words and writes them into the core's message registers. Zero-fills short final blocks, maintains the byte counter `t`, and launches and awaits each compression. After the final block it streams the `nn`-byte digest back out, at full or throttled rate.

## Interface
Parameters:
- `SLOW_DIV`, 4 — cycles per output byte in slow output mode (≥2).

Ports:
- `clk`  in  1  — single clock.
- `nreset`  in  1  — reset, asynchronous, active-low.
- `kk_i`  in  6  — key length in bytes; quasi-static while not IDLE.
- `nn_i`  in  6  — digest length in bytes, 1..32.
- `ll_i`  in  64  — total bytes the host will send, including the 64-byte padded key block when `kk_i`≠0.
- `data_v_i`  in  1  — message byte valid.
- `data_i`  in  8  — message byte.
- `data_idx_i`  in  6  — byte position within the current block.
- `block_first_i`  in  1  — current block is the first block.
- `block_last_i`  in  1  — current block is the last block.
- `slow_output_i`  in  1  — throttle digest output.
- `ready_v_o`  out  1  — block accepts message bytes.
- `m_wr_o`  out  1  — message word write strobe.
- `m_idx_o`  out  4  — message word index.
- `m_word_o`  out  32  — message word.
- `cmp_start_o`  out  1  — one-cycle compression launch.
- `cmp_last_o`  out  1  — finalization flag; valid with `cmp_start_o`.
- `t_o`  out  64  — byte counter; valid with `cmp_start_o`.
- `cmp_done_i`  in  1  — one-cycle compression-complete pulse from the core.
- `h_idx_o`  out  5  — digest byte read index.
- `h_byte_i`  in  8  — digest byte; valid 1 cycle after `h_idx_o`.
- `hash_v_o`  out  1  — digest byte valid.
- `hash_o`  out  8  — digest byte.
- `err_o`  out  1  — sticky protocol error.

## Operation
- States: IDLE, LOAD, FILL, COMP, OUT.
- All outputs are 0 while in reset, and the state is IDLE. After reset: `ready_v_o`=1, `t_q`=0, `err_o`=0.
- `ready_v_o`=1 in IDLE and LOAD only.

**IDLE.** A `data_v_i` with `block_first_i` clears `t_q` and `err_o`, then goes to LOAD and processes the byte.

**LOAD.** Each `data_v_i`:
- Byte goes to lane `b[1:0]` of word `b[5:2]`, where `b` = internal block byte count.
- `t_q` += 1 (64-bit, wrap ignored).
- If `data_idx_i`≠`b`, set `err_o`; the byte is still used.
- The word is written (`m_wr_o`) when lane 3 is filled.
- Block end occurs on:
  - `b`=63 → COMP; or
  - `block_last_i` and `t_q+1`=`ll_i` → partial word written with upper lanes zero, then FILL if word <15, else COMP.

**FILL.** Writes zero words, one per cycle, to indices (last+1)..15, then COMP.

**COMP.**
- Entry cycle: pulse `cmp_start_o`, with `cmp_last_o`=last flag and `t_o`=`t_q`.
- Wait for `cmp_done_i`.
- Then → OUT if last; else → LOAD with `b`=0.

**OUT.**
- Issue `h_idx_o` = 0..`nn_i`-1.
- Each byte appears on `hash_o` with a `hash_v_o` pulse.
- Normal mode: one byte per cycle. Slow mode: one byte per `SLOW_DIV` cycles; `slow_output_i` is sampled on OUT entry.
- After byte `nn_i`-1 → IDLE.

**Errors and boundaries.**
- A `data_v_i` in FILL/COMP/OUT is dropped and sets `err_o`.
- A `data_v_i` with `block_first_i` in IDLE while `err_o`=1 restarts cleanly.
- `cmp_done_i` outside COMP is ignored.
- A `block_last_i` byte at `b`=63 with `t_q+1`≠`ll_i` is treated as a full non-last block and sets `err_o`.
- `ll_i`=0 with `kk_i`=0 is out of scope; the host never issues it.
- Asynchronous reset in any state aborts immediately; no partial writes or strobes follow.

## Timing
- `m_wr_o` is registered, 1 cycle after the `data_v_i` that completes a word.
- `cmp_start_o` follows 1 cycle after the block's final word write, whether from LOAD or FILL.
- `cmp_done_i` → next state: 1 cycle.
- OUT: `h_idx_o` is issued on cycle n; `hash_v_o`/`hash_o` are registered on cycle n+2. First `hash_v_o` occurs 3 cycles after `cmp_done_i`.
- Back-to-back data bytes are accepted every cycle in LOAD.
- Host must not send the next block's bytes until `ready_v_o` returns to 1.

## Test plan
- Reset mid-COMP → all outputs 0, `ready_v_o`=1 next cycle; the later `cmp_done_i` is ignored.
- Unkeyed `ll_i`=3, bytes 61 62 63 with first+last, `nn_i`=32:
  - word 0 = 0x00636261, then zero writes for words 1..15;
  - `cmp_start_o` with `t_o`=3, `cmp_last_o`=1;
  - 32 consecutive `hash_v_o` pulses matching `h_byte_i` for indices 0..31.
- `ll_i`=128, two full blocks:
  - first `cmp_start_o` has `t_o`=64, `cmp_last_o`=0 and no FILL;
  - second has `t_o`=128, `cmp_last_o`=1.
- `ll_i`=64, `kk_i`=8, single key block → 16 writes, no FILL, `t_o`=64, `cmp_last_o`=1.
- Slow mode, `SLOW_DIV`=4, `nn_i`=4 → `hash_v_o` pulses exactly 4 cycles apart, 4 pulses total, then IDLE.
- Protocol errors:
  - byte during COMP → dropped, `err_o`=1, no `m_wr_o`;
  - `data_idx_i` skip → `err_o`=1;
  - new first-block byte in IDLE → `err_o` cleared.
